pid_scheduler: RTL and testbench
================================

# pid_scheduler

Time-multiplexes one shared PI arithmetic core across all wheel-motor channels of the robot drive. Once per control period it walks the enabled channels in order. For each channel it forms the speed error, hands it and that channel's stored integrator state to the core, and writes back the core's drive output and updated integrator. It sits between the encoder/setpoint registers and the PWM stage, and owns every per-motor controller state so that the core itself is stateless.

## Interface
Parameters:
- NUM_MOTORS, 4, number of channels (2..8)
- WIDTH, 16, signed width of setpoint, speed, error, drive output
- IWIDTH, 24, signed width of per-channel integrator state
- TICK_DIV, 50000, clk cycles per control period
- TIMEOUT, 64, max cycles to wait for core_done

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  NUM_MOTORS  per-channel enable
- setpoint  in  NUM_MOTORS*WIDTH  packed signed setpoints, channel 0 in LSBs
- speed  in  NUM_MOTORS*WIDTH  packed signed measured speeds
- core_start  out  1  one-cycle start pulse to the PI core
- core_e  out  WIDTH  error presented to the core
- core_i  out  IWIDTH  integrator state presented to the core
- core_done  in  1  core result valid, one-cycle pulse
- core_u  in  WIDTH  core drive output
- core_i_next  in  IWIDTH  core updated integrator
- u_out  out  NUM_MOTORS*WIDTH  packed drive outputs, frame-coherent
- u_valid  out  1  one-cycle pulse when u_out updates
- busy  out  1  high while a frame is in progress
- overrun  out  1  sticky: tick arrived while busy
- fault  out  NUM_MOTORS  sticky per-channel core timeout

## Operation
- The tick counter runs 0..TICK_DIV-1 and wraps. A tick is asserted in the cycle where the count equals TICK_DIV-1.
- States:
  - IDLE: on tick, go to LOAD with ch = 0 and busy = 1.
  - LOAD: for an enabled channel, register core_e and core_i and pulse core_start, then go to WAIT. For a disabled channel, write u = 0 and integrator = 0, then go to NEXT.
  - WAIT: on core_done, go to STORE. If TIMEOUT cycles elapse with no core_done, set fault[ch], write u = 0 (integrator unchanged), and go to NEXT.
  - STORE: latch core_u into shadow[ch] and core_i_next into integ[ch], then go to NEXT.
  - NEXT: if ch == NUM_MOTORS-1, copy all shadows to u_out, pulse u_valid, clear busy, and go to IDLE. Otherwise increment ch and go to LOAD.
- Error arithmetic: setpoint − speed, computed at WIDTH+1 bits and saturated to the signed WIDTH range. For WIDTH 16 this gives +32767 / −32768.
- A tick while busy sets overrun and is dropped. The frame in progress continues unaffected.
- core_done outside WAIT is ignored.
- Enable changing mid-frame takes effect when that channel reaches LOAD.
- overrun and fault clear only on reset.

## Timing
- Reset values: core_start = 0, core_e = 0, core_i = 0, u_out = 0, u_valid = 0, busy = 0, overrun = 0, fault = 0. All integrators = 0, state = IDLE, counter = 0.
- core_start rises one cycle after entering LOAD. core_e and core_i are held stable from that cycle until leaving WAIT.
- Per enabled channel: 3 cycles plus core latency. Per disabled channel: 2 cycles.
- u_valid is asserted in the cycle after NEXT of the last channel. u_out changes in the same cycle.
- Reset mid-frame aborts the frame immediately, and no partial u_out is published. A core_done arriving after reset is ignored.
- All outputs are registered.

## Structure
- Package pid_sched_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, STORE, NEXT)
  - default WIDTH, IWIDTH and NUM_MOTORS constants
  - a sat_sub function for the saturated subtraction
- Sub-module tick_gen is the TICK_DIV counter producing a one-cycle tick.
- Integrator storage and shadow outputs are register arrays indexed by ch.

## Test plan
- Core model with 4-cycle latency, u = e, i_next = i + e; setpoint 100, speed 40 on all channels; one tick. Required: u_valid once, every u_out lane = 60, integ = 60; after a second tick, integ = 120.
- enable = 4'b0101 after integrators are nonzero. Required: lanes 1 and 3 become 0, their integrators clear, and only two core_start pulses occur per frame.
- setpoint = 32767, speed = −32768. Required: core_e = 32767 (saturated). Reverse the values: core_e = −32768.
- Core never asserts done on channel 2. Required: after 64 WAIT cycles, fault = 4'b0100, lane 2 = 0, and the frame completes.
- TICK_DIV = 10 with core latency 20. Required: overrun = 1, frames are not restarted mid-flight, and u_valid never pulses twice per frame.
- Assert reset in WAIT of channel 1. Required: all outputs at reset values next cycle, u_out unchanged from 0, and a late core_done is ignored.

Source files
------------

// File: rtl/pid_sched_pkg.sv
// Shared definitions for the PI scheduler: controller state encoding,
// default channel/width constants and the saturated error subtraction.
package pid_sched_pkg;

  localparam int DEF_NUM_MOTORS = 4;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_IWIDTH     = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STORE,
    NEXT
  } state_e;

  // a - b evaluated one bit wider than the operands, then clamped to the
  // signed range of a w-bit result (w <= 32). Callers truncate to w bits.
  function automatic logic signed [32:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w);
    logic signed [32:0] d;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    d  = 33'(a) - 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (d > hi)      return hi;
    else if (d < lo) return lo;
    else             return d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Control-period timebase: free-running counter over 0..TICK_DIV-1 that
// raises tick_o for the single cycle in which the count is TICK_DIV-1.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset, count returns to 0
//   tick_o - one-cycle period marker
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/pid_scheduler.sv
// Time-multiplexes one stateless PI core across NUM_MOTORS channels. Each
// control period the enabled channels are walked in order; per channel the
// saturated speed error and stored integrator go to the core, and the core's
// drive value and next integrator are written back. Drive outputs are
// published together at the end of the frame.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   enable              - per-channel enable, sampled when the channel loads
//   setpoint, speed     - packed signed lanes, channel 0 in the LSBs
//   core_start/e/i      - request to the PI core (registered, held during wait)
//   core_done/u/i_next  - core result, valid only while core_done is high
//   u_out, u_valid      - frame-coherent drive outputs and update strobe
//   busy                - frame in progress
//   overrun             - sticky: period tick arrived during a frame
//   fault               - sticky per-channel core timeout
module pid_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NUM_MOTORS = DEF_NUM_MOTORS,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int IWIDTH     = DEF_IWIDTH,
  parameter int TICK_DIV   = 50000,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MOTORS-1:0]        enable,
  input  logic [NUM_MOTORS*WIDTH-1:0]  setpoint,
  input  logic [NUM_MOTORS*WIDTH-1:0]  speed,
  output logic                         core_start,
  output logic signed [WIDTH-1:0]      core_e,
  output logic signed [IWIDTH-1:0]     core_i,
  input  logic                         core_done,
  input  logic signed [WIDTH-1:0]      core_u,
  input  logic signed [IWIDTH-1:0]     core_i_next,
  output logic [NUM_MOTORS*WIDTH-1:0]  u_out,
  output logic                         u_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [NUM_MOTORS-1:0]        fault
);

  localparam int CHW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_MOTORS - 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [CHW-1:0]            ch_q;
  logic [TW-1:0]             wcnt_q;
  logic signed [WIDTH-1:0]   shadow_q [NUM_MOTORS];
  logic signed [IWIDTH-1:0]  integ_q  [NUM_MOTORS];
  logic signed [WIDTH-1:0]   res_u_q;
  logic signed [IWIDTH-1:0]  res_i_q;

  logic                      core_start_q;
  logic signed [WIDTH-1:0]   core_e_q;
  logic signed [IWIDTH-1:0]  core_i_q;
  logic [NUM_MOTORS*WIDTH-1:0] u_out_q;
  logic                      u_valid_q, busy_q, overrun_q;
  logic [NUM_MOTORS-1:0]     fault_q;

  logic tick, ch_en, last_ch, timeout;
  logic signed [WIDTH-1:0]   sp_lane, spd_lane, err;
  logic [NUM_MOTORS*WIDTH-1:0] shadow_flat;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign ch_en   = enable[ch_q];
  assign last_ch = (ch_q == LAST_CH);
  assign timeout = (wcnt_q == TO_LAST);

  always_comb begin
    sp_lane  = setpoint[int'(ch_q)*WIDTH +: WIDTH];
    spd_lane = speed[int'(ch_q)*WIDTH +: WIDTH];
    err      = WIDTH'(sat_sub(32'(sp_lane), 32'(spd_lane), WIDTH));
  end

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      shadow_flat[i*WIDTH +: WIDTH] = shadow_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = LOAD;
      LOAD:    state_d = ch_en ? WAIT : NEXT;
      WAIT: begin
        if (core_done)    state_d = STORE;
        else if (timeout) state_d = NEXT;
      end
      STORE:   state_d = NEXT;
      NEXT:    state_d = last_ch ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q         <= '0;
      wcnt_q       <= '0;
      res_u_q      <= '0;
      res_i_q      <= '0;
      core_start_q <= 1'b0;
      core_e_q     <= '0;
      core_i_q     <= '0;
      u_out_q      <= '0;
      u_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      fault_q      <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        shadow_q[i] <= '0;
        integ_q[i]  <= '0;
      end
    end else begin
      core_start_q <= 1'b0;
      u_valid_q    <= 1'b0;
      // A tick during a frame is dropped; only the sticky flag records it.
      if (tick && busy_q) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (tick) begin
            ch_q   <= '0;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          wcnt_q <= '0;
          if (ch_en) begin
            core_e_q     <= err;
            core_i_q     <= integ_q[ch_q];
            core_start_q <= 1'b1;
          end else begin
            shadow_q[ch_q] <= '0;
            integ_q[ch_q]  <= '0;
          end
        end
        WAIT: begin
          wcnt_q <= wcnt_q + 1'b1;
          // Core results are only guaranteed during the done pulse, so they
          // are captured here and committed in STORE.
          if (core_done) begin
            res_u_q <= core_u;
            res_i_q <= core_i_next;
          end else if (timeout) begin
            fault_q[ch_q]  <= 1'b1;
            shadow_q[ch_q] <= '0;
          end
        end
        STORE: begin
          shadow_q[ch_q] <= res_u_q;
          integ_q[ch_q]  <= res_i_q;
        end
        NEXT: begin
          if (last_ch) begin
            u_out_q   <= shadow_flat;
            u_valid_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_e     = core_e_q;
  assign core_i     = core_i_q;
  assign u_out      = u_out_q;
  assign u_valid    = u_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_pid_scheduler.sv
module tb_pid_scheduler;
  localparam int NM = 4;
  localparam int W  = 16;
  localparam int IW = 24;
  localparam int TD = 100;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset;
  logic [NM-1:0]   enable;
  logic [NM*W-1:0] setpoint, speed;
  logic            core_start;
  logic signed [W-1:0]  core_e;
  logic signed [IW-1:0] core_i;
  logic            core_done;
  logic signed [W-1:0]  core_u;
  logic signed [IW-1:0] core_i_next;
  logic [NM*W-1:0] u_out;
  logic            u_valid, busy, overrun;
  logic [NM-1:0]   fault;

  pid_scheduler #(.NUM_MOTORS(NM), .WIDTH(W), .IWIDTH(IW), .TICK_DIV(TD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .setpoint(setpoint), .speed(speed),
    .core_start(core_start), .core_e(core_e), .core_i(core_i),
    .core_done(core_done), .core_u(core_u), .core_i_next(core_i_next),
    .u_out(u_out), .u_valid(u_valid), .busy(busy), .overrun(overrun), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct { int e; int i; } start_t;
  typedef struct { logic [NM*W-1:0] u; logic [NM-1:0] flt; int nst; } frame_t;

  start_t sq[$];
  frame_t fq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int m_integ [NM];
  logic [NM-1:0] m_fault;
  int mute_ch = -1;
  int lat = 4;

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(int a, int b);
    int d;
    d = a - b;
    if (d > 32767)  return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  function automatic int wrap_i(int x);
    logic signed [IW-1:0] t;
    t = x[IW-1:0];
    return int'(t);
  endfunction

  function automatic int lane(logic [NM*W-1:0] v, int c);
    logic signed [W-1:0] t;
    t = v[c*W +: W];
    return int'(t);
  endfunction

  function automatic int nth_enabled(int k);
    int n;
    n = 0;
    for (int c = 0; c < NM; c++) begin
      if (enable[c]) begin
        if (n == k) return c;
        n++;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NM; c++) m_integ[c] = 0;
    m_fault = '0;
    sq.delete();
    fq.delete();
  endtask

  // Reference model: what one frame should produce given current inputs.
  task automatic issue_frame();
    frame_t f;
    start_t s;
    int e;
    f.u = '0;
    f.nst = 0;
    for (int c = 0; c < NM; c++) begin
      if (enable[c]) begin
        e = sat(lane(setpoint, c), lane(speed, c));
        s.e = e;
        s.i = m_integ[c];
        sq.push_back(s);
        f.nst++;
        if (c == mute_ch) m_fault[c] = 1'b1;
        else begin
          f.u[c*W +: W] = e[W-1:0];
          m_integ[c] = wrap_i(m_integ[c] + e);
        end
      end else begin
        m_integ[c] = 0;
      end
    end
    f.flt = m_fault;
    fq.push_back(f);
  endtask

  task automatic wait_frame(int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!u_valid && k < budget);
    check("frame_completes", u_valid, 1);
    check("busy_clear_at_u_valid", busy, 0);
  endtask

  task automatic run_frame();
    issue_frame();
    wait_frame(400);
  endtask

  task automatic set_all(int sp, int spd);
    for (int c = 0; c < NM; c++) begin
      setpoint[c*W +: W] = sp[W-1:0];
      speed[c*W +: W]    = spd[W-1:0];
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_e"}, core_e, 0);
    check({tag, "_core_i"}, core_i, 0);
    check({tag, "_u_out"}, longint'(u_out), 0);
    check({tag, "_u_valid"}, u_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  // PI core stand-in: u = e, i_next = i + e, after 'lat' cycles; result
  // buses carry noise outside the done pulse. mute_ch never answers.
  initial begin
    int cnt;
    bit pend;
    int k;
    int ch;
    logic signed [W-1:0]  ce;
    logic signed [IW-1:0] ci;
    cnt = 0; pend = 0; k = 0; ce = '0; ci = '0;
    core_done = 1'b0; core_u = '0; core_i_next = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      core_u = W'($urandom);
      core_i_next = IW'($urandom);
      if (reset || u_valid) k = 0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          core_done = 1'b1;
          core_u = ce;
          core_i_next = ci + IW'(ce);
        end
      end
      if (core_start && !reset) begin
        ch = nth_enabled(k);
        k++;
        ce = core_e;
        ci = core_i;
        if (ch != mute_ch) begin
          pend = 1;
          cnt = lat - 1;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int starts;
    start_t s;
    frame_t f;
    starts = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        starts = 0;
      end else begin
        if (core_start) begin
          starts++;
          check("start_expected", int'(sq.size() != 0), 1);
          if (sq.size() != 0) begin
            s = sq.pop_front();
            check("core_e", core_e, s.e);
            check("core_i", core_i, s.i);
          end
        end
        if (u_valid) begin
          check("u_valid_expected", int'(fq.size() != 0), 1);
          if (fq.size() != 0) begin
            f = fq.pop_front();
            for (int c = 0; c < NM; c++)
              check($sformatf("u_lane%0d", c), lane(u_out, c), lane(f.u, c));
            check("fault", fault, f.flt);
            check("starts_per_frame", starts, f.nst);
          end
          starts = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int quiet_bad;
    logic [W-1:0] a, b;
    reset = 1'b1;
    enable = '1;
    setpoint = '0;
    speed = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Basic: e = 60, integrator 60 then 120 (seen via core_i of later frames).
    set_all(100, 40);
    lat = 4;
    run_frame();
    @(posedge clk); #1;
    check("u_valid_one_cycle", u_valid, 0);
    run_frame();
    run_frame();

    // Partially enabled frame clears lanes 1,3 and their integrators.
    enable = 4'b0101;
    run_frame();
    enable = 4'b1111;
    run_frame();

    // Saturation in both directions.
    set_all(32767, -32768);
    run_frame();
    set_all(-32768, 32767);
    run_frame();

    // Channel 2 core timeout.
    set_all(100, 40);
    mute_ch = 2;
    run_frame();
    mute_ch = -1;
    check("fault_after_timeout", fault, 4'b0100);

    // Randomised frames.
    for (int r = 0; r < 12; r++) begin
      enable = NM'($urandom);
      for (int c = 0; c < NM; c++) begin
        a = W'($urandom);
        b = W'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          a = 16'h7fff;
          b = 16'h8000;
        end
        setpoint[c*W +: W] = a;
        speed[c*W +: W] = b;
      end
      lat = $urandom_range(2, 6);
      run_frame();
    end
    check("no_overrun_yet", overrun, 0);

    // Slow core: frame outlasts the period.
    enable = '1;
    set_all(100, 40);
    lat = 30;
    run_frame();
    run_frame();
    check("overrun_set", overrun, 1);
    check("fault_still_sticky", fault, 4'b0100);

    // Reset while waiting on channel 1.
    lat = 4;
    issue_frame();
    n = 0;
    for (int k = 0; k < 400 && n < 2; k++) begin
      @(posedge clk); #1;
      if (core_start) n++;
    end
    check("reached_ch1_wait", n, 2);
    check("busy_mid_frame", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midframe_reset");
    model_reset();
    reset = 1'b0;
    quiet_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (u_valid || busy || core_start) quiet_bad++;
    end
    check("late_done_ignored", quiet_bad, 0);
    check("u_out_after_reset", longint'(u_out), 0);
    set_all(100, 40);
    run_frame();
    check("overrun_after_reset", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
